// File: rtl/j1_boot_loader_if.sv
// j1_boot_loader_if: UART RX byte stream plus code RAM write port of the j1 boot loader.
interface j1_boot_loader_if #(
    parameter int ADDR_WIDTH = 13
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [15:0]           ram_wdata;
    logic                  ram_we;
    modport master (
        input  rx_data, rx_valid,
        output rx_ready, ram_addr, ram_wdata, ram_we
    );
    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/j1_boot_loader.sv
// j1_boot_loader: loads a framed little-endian word image into code RAM, then releases the core.
// Define J1_BOOT_CSUM_EN to expect a trailing XOR checksum byte and flag mismatches.
module j1_boot_loader #(
    parameter int         ADDR_WIDTH = 13,
    parameter logic [7:0] MAGIC      = 8'hA5,
    parameter int         TIMEOUT    = 100000
) (
    input  logic             clk,
    input  logic             reset,
    j1_boot_loader_if.master bus,
    output logic             cpu_reset,
    output logic             busy,
    output logic             error
);
    localparam int IW = $clog2(TIMEOUT + 1);
    typedef enum logic [3:0] {SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, FINISH, RUN, ERROR} state_t;
`ifdef J1_BOOT_CSUM_EN
    localparam state_t DONE = CSUM;
`else
    localparam state_t DONE = FINISH;
`endif
    state_t                state_q, state_d;
    logic [15:0]           rem_q, rem_d, ram_wdata_q, ram_wdata_d;
    logic [7:0]            lo_q, lo_d, csum_q, csum_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d, ram_addr_q, ram_addr_d;
    logic [IW-1:0]         idle_q, idle_d;
    logic                  ram_we_q, ram_we_d, rx_ready_q, rx_ready_d;
    logic                  cpu_reset_q, cpu_reset_d, busy_q, busy_d, error_q, error_d;
    logic                  acc, in_frame;
    always_comb begin
        acc         = bus.rx_valid & rx_ready_q;
        in_frame    = state_q inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM};
        state_d     = state_q;
        rem_d       = rem_q;
        lo_d        = lo_q;
        csum_d      = csum_q;
        idx_d       = idx_q;
        idle_d      = '0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        if (state_q == FINISH) begin
            state_d = RUN;
        end else if (acc) begin
            csum_d = csum_q ^ bus.rx_data;
            case (state_q)
                SYNC: if (bus.rx_data == MAGIC) begin
                    state_d = LEN_LO;
                    idx_d   = '0;
                    csum_d  = '0;
                end
                LEN_LO: begin
                    rem_d   = {8'h00, bus.rx_data};
                    state_d = LEN_HI;
                end
                LEN_HI: begin
                    rem_d   = {bus.rx_data, rem_q[7:0]};
                    state_d = (rem_d == 16'h0) ? DONE : DATA_LO;
                end
                DATA_LO: begin
                    lo_d    = bus.rx_data;
                    state_d = DATA_HI;
                end
                DATA_HI: begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = idx_q;
                    ram_wdata_d = {bus.rx_data, lo_q};
                    idx_d       = idx_q + 1'b1;
                    rem_d       = rem_q - 1'b1;
                    state_d     = (rem_q == 16'h1) ? DONE : DATA_LO;
                end
                CSUM: state_d = (bus.rx_data == csum_q) ? FINISH : ERROR;
                default: ;
            endcase
        end else if (in_frame) begin
            // Idle cycles abandon the frame; words already written stay in RAM.
            if (idle_q == IW'(TIMEOUT - 1)) begin
                state_d = SYNC;
                idx_d   = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
        rx_ready_d  = state_d inside {SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM};
        cpu_reset_d = state_d != RUN;
        busy_d      = state_d inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, FINISH};
`ifdef J1_BOOT_CSUM_EN
        error_d     = state_d == ERROR;
`else
        error_d     = 1'b0;
`endif
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SYNC;
            rem_q       <= '0;
            lo_q        <= '0;
            csum_q      <= '0;
            idx_q       <= '0;
            idle_q      <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            rx_ready_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            lo_q        <= lo_d;
            csum_q      <= csum_d;
            idx_q       <= idx_d;
            idle_q      <= idle_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            rx_ready_q  <= rx_ready_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end
    assign bus.rx_ready  = rx_ready_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_we    = ram_we_q;
    assign cpu_reset     = cpu_reset_q;
    assign busy          = busy_q;
    assign error         = error_q;
endmodule

// File: tb/tb_j1_boot_loader.sv
// tb_j1_boot_loader: randomized frames checked every cycle against a byte-position model of the loader.
module tb_j1_boot_loader;
    localparam int AW = 4;
    localparam int TO = 16;
    localparam logic [7:0] MAGIC = 8'hA5;
`ifdef J1_BOOT_CSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif
    localparam int M_HUNT = 0, M_FRAME = 1, M_FIN = 2, M_RUN = 3, M_ERR = 4;

    logic clk, reset, cpu_reset, busy, error;
    int n_cmp = 0, n_bad = 0;

    j1_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();
    j1_boot_loader #(.ADDR_WIDTH(AW), .MAGIC(MAGIC), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus.master),
        .cpu_reset(cpu_reset), .busy(busy), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks position within the frame rather than a state machine.
    bit started = 0;
    int mode = M_HUNT, pos, nlen, wi, idle;
    logic [7:0] x, lo;
    logic e_ready, e_we, e_cpu, e_busy, e_err;
    int e_addr;
    logic [15:0] e_wdata;
    int e_log_addr[$];
    logic [15:0] e_log_data[$];

    always @(posedge clk) begin
        bit acc;
        if (reset) begin
            started = 1;
            mode = M_HUNT;
            idle = 0;
            e_we = 0;
            e_addr = 0;
            e_wdata = 0;
            e_ready = 0;
            e_cpu = 1;
            e_busy = 0;
            e_err = 0;
        end else if (started) begin
            acc = bus.rx_valid && e_ready;
            e_we = 0;
            if (mode == M_FIN) mode = M_RUN;
            else if (mode == M_FRAME) begin
                if (acc) begin
                    idle = 0;
                    if (pos == 0) begin
                        nlen = int'(bus.rx_data);
                        x ^= bus.rx_data;
                    end else if (pos == 1) begin
                        nlen += 256 * int'(bus.rx_data);
                        x ^= bus.rx_data;
                    end else if (pos < 2 + 2 * nlen) begin
                        x ^= bus.rx_data;
                        if ((pos - 2) % 2 == 0) lo = bus.rx_data;
                        else begin
                            e_we = 1;
                            e_addr = wi % (1 << AW);
                            e_wdata = {bus.rx_data, lo};
                            e_log_addr.push_back(e_addr);
                            e_log_data.push_back(e_wdata);
                            wi++;
                        end
                    end else mode = (bus.rx_data == x) ? M_FIN : M_ERR;
                    pos++;
                    if (mode == M_FRAME && !CS && pos == 2 + 2 * nlen) mode = M_FIN;
                end else begin
                    idle++;
                    if (idle == TO) mode = M_HUNT;
                end
            end else if (mode == M_HUNT && acc && bus.rx_data == MAGIC) begin
                mode = M_FRAME;
                pos = 0;
                x = 0;
                wi = 0;
                idle = 0;
            end
            e_ready = (mode == M_HUNT) || (mode == M_FRAME);
            e_cpu = mode != M_RUN;
            e_busy = (mode == M_FRAME) || (mode == M_FIN);
            e_err = mode == M_ERR;
        end
    end

    int d_addr[$];
    logic [15:0] d_data[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_loop();
        forever begin
            @(negedge clk);
            if (bus.ram_we === 1'b1) begin
                d_addr.push_back(int'(bus.ram_addr));
                d_data.push_back(bus.ram_wdata);
            end
            if (started) begin
                check("rx_ready", bus.rx_ready, e_ready);
                check("ram_we", bus.ram_we, e_we);
                check("cpu_reset", cpu_reset, e_cpu);
                check("busy", busy, e_busy);
                check("error", error, e_err);
                if (e_we) begin
                    check("ram_addr", bus.ram_addr, e_addr);
                    check("ram_wdata", bus.ram_wdata, e_wdata);
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            bus.rx_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        bit ok = 0;
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            ok = bus.rx_ready;
            #1;
        end
        bus.rx_valid = 1'b0;
        check("ready_wait", ok, 1);
        idle_cycles($urandom_range(0, maxgap));
    endtask

    task automatic send_frame(input logic [7:0] d[$], input int maxgap, input bit bad);
        logic [15:0] n = 16'(d.size() / 2);
        logic [7:0] cs = n[7:0] ^ n[15:8];
        send_byte(MAGIC, maxgap);
        send_byte(n[7:0], maxgap);
        send_byte(n[15:8], maxgap);
        foreach (d[i]) begin
            cs ^= d[i];
            send_byte(d[i], maxgap);
        end
        if (CS) send_byte(bad ? ~cs : cs, maxgap);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        int bd, be, n;
        bit bad;
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        fork
            cmp_loop();
        join_none
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("rst_ready", bus.rx_ready, 0);
        check("rst_cpu", cpu_reset, 1);
        check("rst_addr", bus.ram_addr, 0);
        check("rst_wdata", bus.ram_wdata, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("sync_ready", bus.rx_ready, 1);

        // Basic two-word frame, back-to-back bytes
        bd = d_data.size();
        be = e_log_data.size();
        q = '{8'h34, 8'h12, 8'h78, 8'h56};
        send_frame(q, 0, 0);
        check("t1_last_we", bus.ram_we, CS ? 0 : 1);
        check("t1_cpu_fin", cpu_reset, 1);
        @(posedge clk);
        #1;
        check("t1_cpu_run", cpu_reset, 0);
        check("t1_nw", d_data.size() - bd, 2);
        check("t1_w0", {d_addr[bd], d_data[bd]}, {16'd0, 16'h1234});
        check("t1_w1", {d_addr[bd+1], d_data[bd+1]}, {16'd1, 16'h5678});
        check("t1_model_w0", e_log_data[be], 16'h1234);
        check("t1_model_w1", e_log_data[be+1], 16'h5678);
        bus.rx_valid = 1'b1;
        idle_cycles(8);
        bus.rx_valid = 1'b0;
        check("t1_run_ready", bus.rx_ready, 0);

        // Garbage before sync, random gaps
        do_reset();
        bd = d_data.size();
        send_byte(8'h00, 2);
        send_byte(8'hFF, 2);
        send_byte(8'h5A, 2);
        send_frame(q, 3, 0);
        idle_cycles(3);
        check("t2_nw", d_data.size() - bd, 2);
        check("t2_w0", {d_addr[bd], d_data[bd]}, {16'd0, 16'h1234});
        check("t2_w1", {d_addr[bd+1], d_data[bd+1]}, {16'd1, 16'h5678});
        check("t2_cpu", cpu_reset, 0);

        // Bad checksum (only meaningful with checksum enabled)
        do_reset();
        bd = d_data.size();
        send_frame(q, 1, 1);
        idle_cycles(3);
        check("t3_nw", d_data.size() - bd, 2);
        check("t3_error", error, CS ? 1 : 0);
        check("t3_cpu", cpu_reset, CS ? 1 : 0);
        check("t3_ready", bus.rx_ready, 0);

        // Timeout mid-frame, then a fresh frame
        do_reset();
        bd = d_data.size();
        send_byte(MAGIC, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h34, 0);
        idle_cycles(20);
        check("t4_busy", busy, 0);
        check("t4_ready", bus.rx_ready, 1);
        q = '{8'hCD, 8'hAB};
        send_frame(q, 0, 0);
        idle_cycles(3);
        check("t4_nw", d_data.size() - bd, 1);
        check("t4_w0", {d_addr[bd], d_data[bd]}, {16'd0, 16'hABCD});
        check("t4_cpu", cpu_reset, 0);

        // Empty frame
        do_reset();
        bd = d_data.size();
        q.delete();
        send_frame(q, 0, 0);
        idle_cycles(3);
        check("t5_nw", d_data.size() - bd, 0);
        check("t5_cpu", cpu_reset, 0);

        // Reset while the high data byte is being accepted
        do_reset();
        bd = d_data.size();
        send_byte(MAGIC, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h34, 0);
        bus.rx_data = 8'h12;
        bus.rx_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        reset = 1'b0;
        check("t6_we", bus.ram_we, 0);
        check("t6_cpu", cpu_reset, 1);
        check("t6_busy", busy, 0);
        idle_cycles(2);
        check("t6_nw", d_data.size() - bd, 0);

        // Random frames, including address wrap for N > 2^AW
        for (int it = 0; it < 30; it++) begin
            do_reset();
            bd = d_data.size();
            repeat ($urandom_range(0, 3)) begin
                logic [7:0] g = 8'($urandom);
                send_byte(g == MAGIC ? 8'h00 : g, 2);
            end
            n = $urandom_range(0, 20);
            q.delete();
            repeat (2 * n) q.push_back(8'($urandom));
            bad = $urandom_range(0, 5) == 0;
            send_frame(q, 3, bad);
            idle_cycles(3);
            check("rnd_nw", d_data.size() - bd, n);
            check("rnd_cpu", cpu_reset, (CS && bad) ? 1 : 0);
            if (n > (1 << AW)) check("rnd_wrap_addr", d_addr[bd + (1 << AW)], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
